// File: rtl/fht_pkg.sv
// ============================================================================
// fht_pkg
// Shared FHT types and helpers: size derivation, loader state encoding and
// the bit-reversal function reused by controller-side tests.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fht_pkg;

    localparam int FHT_BANKS      = 4;
    localparam int FHT_MIN_POINTS = 16;

    typedef enum logic [1:0] {
        LD_LOAD      = 2'd0,
        LD_START     = 2'd1,
        LD_WAIT_LOW  = 2'd2,
        LD_WAIT_HIGH = 2'd3
    } fht_ld_state_t;

    function automatic int fht_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Per-bank address width: four banks share the N points.
    function automatic int fht_a_bit(input int n);
        return fht_log2(n) - 2;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits) r[i] = v[bits - 1 - i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fht_bitrev_addr.sv
// ============================================================================
// fht_bitrev_addr
// Maps a sample index k to {bank, per-bank address}. With FHT_BITREV_EN the
// index is bit-reversed first; otherwise natural order is used.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fht_bitrev_addr
    import fht_pkg::*;
#(
    parameter int N_POINTS = 1024,
    parameter int A_BIT    = fht_a_bit(N_POINTS)
) (
    input  logic [fht_log2(N_POINTS)-1:0] i_k,
    output logic [1:0]                    o_bank,
    output logic [A_BIT-1:0]              o_addr
);

    localparam int C_LOG2N = fht_log2(N_POINTS);

    logic [C_LOG2N-1:0] w_r;

`ifdef FHT_BITREV_EN
    generate
        for (genvar gi = 0; gi < C_LOG2N; gi++) begin : g_rev
            assign w_r[gi] = i_k[C_LOG2N - 1 - gi];
        end
    endgenerate
`else
    assign w_r = i_k;
`endif

    // Low two bits pick the bank so consecutive positions stripe across banks.
    assign o_bank = w_r[1:0];
    assign o_addr = w_r[C_LOG2N-1:2];

endmodule

`default_nettype wire

// File: rtl/fht_loader.sv
// ============================================================================
// fht_loader
// Writes a frame of N samples into the four FHT RAM banks, then starts the
// transform and holds off input until it completes. Macro: FHT_BITREV_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fht_loader
    import fht_pkg::*;
#(
    parameter int N_POINTS = 1024,
    parameter int D_BIT    = 16,
    parameter int A_BIT    = fht_a_bit(N_POINTS)
) (
    input  logic                          iCLK,
    input  logic                          iRESET,
    input  logic [D_BIT-1:0]              iDATA,
    input  logic                          iVALID,
    output logic                          oREADY,
    input  logic                          iRDY,
    output logic                          oSTART,
    output logic [D_BIT-1:0]              oDATA_WR,
    output logic [A_BIT-1:0]              oADDR_WR,
    output logic [3:0]                    oWE,
    output logic                          oBUSY,
    output logic [fht_log2(N_POINTS)-1:0] oCNT
);

    localparam int                 C_LOG2N = fht_log2(N_POINTS);
    localparam logic [C_LOG2N-1:0] C_LAST  = '1;

    fht_ld_state_t        r_state;
    logic [C_LOG2N-1:0]   r_cnt;
    logic                 r_ready;
    logic                 r_start;
    logic                 r_busy;
    logic [3:0]           r_we;
    logic [A_BIT-1:0]     r_addr;
    logic [D_BIT-1:0]     r_data;

    logic                 w_ready;
    logic                 w_xfer;
    logic [1:0]           w_bank;
    logic [A_BIT-1:0]     w_addr;

    fht_bitrev_addr #(
        .N_POINTS (N_POINTS),
        .A_BIT    (A_BIT)
    ) u_map (
        .i_k    (r_cnt),
        .o_bank (w_bank),
        .o_addr (w_addr)
    );

    // Reset masks the handshake and any in-flight write in the same cycle.
    assign w_ready = r_ready & ~iRESET;
    assign w_xfer  = iVALID & w_ready;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state <= LD_LOAD;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_we    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_we    <= '0;
            r_start <= 1'b0;
            case (r_state)
                LD_LOAD: begin
                    if (w_xfer) begin
                        r_we   <= 4'b0001 << w_bank;
                        r_addr <= w_addr;
                        r_data <= iDATA;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state <= LD_START;
                            r_ready <= 1'b0;
                        end
                    end
                end
                LD_START: begin
                    r_start <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= LD_WAIT_LOW;
                end
                // The controller may take several cycles to drop RDY.
                LD_WAIT_LOW: begin
                    if (!iRDY) r_state <= LD_WAIT_HIGH;
                end
                LD_WAIT_HIGH: begin
                    if (iRDY) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= LD_LOAD;
                    end
                end
                default: begin
                    r_state <= LD_LOAD;
                end
            endcase
        end
    end

    assign oREADY   = w_ready;
    assign oSTART   = r_start;
    assign oBUSY    = r_busy;
    assign oWE      = r_we & {4{~iRESET}};
    assign oADDR_WR = r_addr;
    assign oDATA_WR = r_data;
    assign oCNT     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fht_loader.sv
// ============================================================================
// tb_fht_loader
// Self-checking bench for fht_loader at N_POINTS=16.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fht_loader;

    localparam int N     = 16;
    localparam int D     = 16;
    localparam int LOG2N = 4;
    localparam int A     = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic           rdy;
    logic [D-1:0]   data;
    logic           ready;
    logic           start;
    logic [D-1:0]   data_wr;
    logic [A-1:0]   addr_wr;
    logic [3:0]     we;
    logic           busy;
    logic [LOG2N-1:0] cnt;

    int checks   = 0;
    int failures = 0;
    logic [15:0] seen;

    typedef struct {
        int k;
        int bank;
        int addr;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    fht_loader #(
        .N_POINTS (N),
        .D_BIT    (D),
        .A_BIT    (A)
    ) dut (
        .iCLK     (clk),
        .iRESET   (rst),
        .iDATA    (data),
        .iVALID   (valid),
        .oREADY   (ready),
        .iRDY     (rdy),
        .oSTART   (start),
        .oDATA_WR (data_wr),
        .oADDR_WR (addr_wr),
        .oWE      (we),
        .oBUSY    (busy),
        .oCNT     (cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM position of sample k: reversed binary digits, or k itself.
    function automatic int ref_pos(input int k);
        int r;
        int v;
        r = k;
`ifdef FHT_BITREV_EN
        r = 0;
        v = k;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
`else
        v = 0;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_sample(input int k);
        logic [D-1:0] d;
        int pos;
        d     = D'($urandom);
        valid = 1'b1;
        data  = d;
        chk("ready_in_load", ready, 1'b1);
        tick();
        pos = ref_pos(k);
        chk("we", we, 32'(1 << (pos % 4)));
        chk("addr_wr", addr_wr, pos / 4);
        chk("data_wr", data_wr, d);
        chk("cnt", cnt, (k + 1) % N);
        for (int j = 0; j < 4; j++) begin
            if (vecs[j].k == k) begin
                chk("table_we", we, 32'(1 << vecs[j].bank));
                chk("table_addr", addr_wr, vecs[j].addr);
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (we[b]) seen[int'(addr_wr) * 4 + b] = 1'b1;
        end
    endtask

    // Called one cycle after the final transfer; drives the controller RDY.
    task automatic finish_frame(input int low_delay, input int low_len);
        int found;
        int lat;
        int n_start;
        chk("ready_drop", ready, 1'b0);
        chk("start_early", start, 1'b0);
        found = 0;
        lat   = 0;
        for (int c = 0; c < 4 && found == 0; c++) begin
            valid = 1'(($urandom >> 3) & 1);
            tick();
            lat++;
            if (start) found = 1;
            chk("we_after_frame", we, 4'b0000);
        end
        chk("start_seen", found, 1);
        chk("start_latency", lat, 1);
        chk("busy_rise", busy, 1'b1);
        n_start = 1;
        for (int c = 0; c < low_delay + low_len; c++) begin
            if (c == low_delay) rdy = 1'b0;
            valid = 1'(($urandom >> 5) & 1);
            tick();
            chk("ready_busy", ready, 1'b0);
            chk("we_busy", we, 4'b0000);
            chk("busy_hold", busy, 1'b1);
            if (start) n_start++;
        end
        rdy   = 1'b1;
        valid = 1'b0;
        tick();
        chk("ready_return", ready, 1'b1);
        chk("busy_fall", busy, 1'b0);
        chk("start_count", n_start, 1);
    endtask

    initial begin
        int acc;
        int pos;
        logic v;
        logic [D-1:0] d;

`ifdef FHT_BITREV_EN
        vecs[0] = '{k: 1, bank: 0, addr: 2};
        vecs[1] = '{k: 2, bank: 0, addr: 1};
        vecs[2] = '{k: 3, bank: 0, addr: 3};
        vecs[3] = '{k: 4, bank: 2, addr: 0};
`else
        vecs[0] = '{k: 5,  bank: 1, addr: 1};
        vecs[1] = '{k: 15, bank: 3, addr: 3};
        vecs[2] = '{k: 1,  bank: 1, addr: 0};
        vecs[3] = '{k: 8,  bank: 0, addr: 2};
`endif

        rst   = 1'b1;
        valid = 1'b0;
        rdy   = 1'b1;
        data  = '0;
        seen  = '0;
        tick();
        tick();
        chk("rst_ready", ready, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", we, 4'b0000);
        chk("rst_addr", addr_wr, 0);
        chk("rst_data", data_wr, 0);
        chk("rst_cnt", cnt, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", ready, 1'b1);

        // Continuous frame.
        for (int k = 0; k < N; k++) load_sample(k);
        chk("unique_positions", seen, 16'hFFFF);
        finish_frame(3, 40);

        // Frame with random VALID gaps.
        acc = 0;
        for (int c = 0; c < 200 && acc < N; c++) begin
            v     = 1'($urandom & 1);
            d     = D'($urandom);
            valid = v;
            data  = d;
            chk("gap_ready", ready, 1'b1);
            tick();
            if (v) begin
                pos = ref_pos(acc);
                chk("gap_we", we, 32'(1 << (pos % 4)));
                chk("gap_addr", addr_wr, pos / 4);
                chk("gap_data", data_wr, d);
                acc++;
            end else begin
                chk("gap_idle_we", we, 4'b0000);
            end
            chk("gap_cnt", cnt, acc % N);
        end
        chk("gap_frame_done", acc, N);
        finish_frame(1, 5);

        // Reset after 7 samples, then a clean frame.
        for (int k = 0; k < 7; k++) load_sample(k);
        rst   = 1'b1;
        valid = 1'b1;
        #1;
        chk("we_cancel", we, 4'b0000);
        chk("ready_in_rst", ready, 1'b0);
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        #1;
        chk("cnt_after_rst", cnt, 0);
        chk("we_after_rst", we, 4'b0000);
        chk("ready_after_mid_rst", ready, 1'b1);
        chk("busy_after_rst", busy, 1'b0);
        for (int k = 0; k < N; k++) load_sample(k);
        finish_frame(2, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fht_loader.md
# fht_loader

Input-side writer for the FHT core. Accepts a stream of N time-domain samples over a valid/ready handshake and writes each into one of the four FHT data RAM banks at its bit-reversed position. After the last sample it pulses the start input of `fht_control`, then holds off new input until the transform reports ready. It is the write-end counterpart of `fht_control`'s read-address generation and sits between the sample source and bank A of the FHT RAM.

## Interface
- `N_POINTS`, 1024: transform length; power of two, ≥16.
- `D_BIT`, 16: sample width.
- `A_BIT`, log2(N_POINTS/4): per-bank address width (8 at default).
- `iCLK` in 1: clock; all logic on rising edge.
- `iRESET` in 1: synchronous, active-high reset.
- `iDATA` in D_BIT: input sample.
- `iVALID` in 1: `iDATA` valid.
- `oREADY` out 1: loader accepts a sample this cycle.
- `iRDY` in 1: `oRDY` of `fht_control`.
- `oSTART` out 1: one-cycle start pulse to `fht_control` `iSTART`.
- `oDATA_WR` out D_BIT: RAM write data.
- `oADDR_WR` out A_BIT: RAM write address (per bank).
- `oWE` out 4: one-hot bank write enable.
- `oBUSY` out 1: high from the `oSTART` pulse until the transform completes.
- `oCNT` out log2(N_POINTS): number of samples accepted in the current frame.

## Operation
- States: LOAD, START, WAIT_LOW, WAIT_HIGH.
- LOAD: `oREADY`=1. A transfer occurs when `iVALID & oREADY`.
  - On a transfer, register the sample with index k=`oCNT` and increment `oCNT`.
  - On the transfer with k=N_POINTS-1, `oCNT` wraps to 0 and the FSM goes to START.
- START: `oREADY`=0, `oSTART`=1 for exactly one cycle, `oBUSY`←1, go to WAIT_LOW.
- WAIT_LOW: `oREADY`=0. When `iRDY`=0, go to WAIT_HIGH. Handles a controller that drops RDY with any latency ≥1.
- WAIT_HIGH: `oREADY`=0. When `iRDY`=1, `oBUSY`←0 and go to LOAD.
- Address mapping: r = bit-reverse of k over log2(N_POINTS) bits.
  - Bank = r[1:0]; `oWE` = 1<<bank.
  - `oADDR_WR` = r[log2N-1:2].
- `iVALID` is ignored outside LOAD. `iDATA` may change freely while not transferred.
- Reset mid-operation (any state): return to LOAD, `oCNT`=0, and drop any partial frame. An in-flight `oWE` is cancelled in the reset cycle.

## Timing
- Reset values: `oREADY`=0 during the reset cycle and 1 on the first cycle after; `oSTART`=0, `oBUSY`=0, `oWE`=0, `oADDR_WR`=0, `oDATA_WR`=0, `oCNT`=0.
- Write latency: 1 cycle. A transfer at edge t produces registered `oWE`/`oADDR_WR`/`oDATA_WR` valid during cycle t+1, for one cycle only.
- `oSTART` is asserted in the cycle after the last write is presented, so the last RAM write completes before or with the start edge.
- `oREADY` drops in the cycle after the final transfer, so no back-to-back transfer into a 17th (N+1th) slot is possible.
- Input throughput: one sample per cycle in LOAD.
- Minimum dead time between frames: 3 cycles plus the transform duration.

## Configuration
- `FHT_BITREV_EN` defined: bit-reversed mapping as above.
- Undefined: natural order, r = k (bank = k[1:0], address = k>>2). This build is for controllers that perform the reordering on their first stage.
- The macro has no effect on the FSM, handshake or timing.

## Structure
- Shared package `fht_pkg`:
  - `N_POINTS`/`A_BIT` derivation function.
  - State typedef `fht_ld_state_t`.
  - `bitrev` function, which `fht_control` tests reuse.
- One sub-module is natural: `fht_bitrev_addr`, a combinational k→{bank, addr} mapper under `FHT_BITREV_EN`, instantiated once.

## Test plan
- `N_POINTS`=16, `FHT_BITREV_EN` defined, continuous `iVALID`, k=0..15 → k=1 writes bank0/addr2; k=2 bank0/addr1; k=3 bank0/addr3; k=4 bank2/addr0. All 16 (bank,addr) pairs are unique.
- Same stream with the macro undefined → k=5 writes bank1/addr1; k=15 writes bank3/addr3.
- After the 16th transfer → `oREADY`=0 on the next cycle; `oSTART` is a single-cycle pulse one cycle after the last `oWE`; `oBUSY` rises with it.
- Model `iRDY`: low 3 cycles after `oSTART`, high 40 cycles later → `oREADY` stays 0 throughout and returns to 1 the cycle after `iRDY` rises. `iVALID` pulses during BUSY produce no `oWE`.
- Random `iVALID` gaps (50%) → only handshaken samples are written; `oCNT` equals the accepted count.
- Assert `iRESET` after 7 samples → next cycle: `oCNT`=0, `oWE`=0, state LOAD. A full 16-sample frame afterwards yields exactly one `oSTART`.
